pwm_capture: RTL and testbench

- Receive-side counterpart of the phase driver: decodes a complementary PWM pair (pwm_h / pwm_l) back into a duty-cycle word and a period measurement.
- Flags high-Z (both legs off) and shoot-through (both legs on) conditions.
- Used on the FPGA for loopback self-test of the motor phase outputs and for monitoring gate-drive behaviour.
- Single clock domain; pins are asynchronous to the clock and are synchronized internally.

---
 rtl/pwm_capture_pkg.sv | 26 ++
 rtl/pwm_capture_sync_edge.sv | 46 ++++
 rtl/pwm_capture.sv | 207 ++++++++++++++++++++
 tb/tb_pwm_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_pkg
// Description : Shared constants for the PWM capture block: default duty
//               width (mirrors the phase driver's duty word), default timeout
//               and high-Z thresholds, and the capture FSM state encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    // Width of the duty word shared with the phase driver.
    localparam int c_DEF_DUTY_CYCLE_WIDTH = 8;

    // Default thresholds used as top-level parameter defaults.
    localparam int c_DEF_CNT_WIDTH    = 16;
    localparam int c_DEF_TIMEOUT_CLKS = 1024;
    localparam int c_DEF_HIZ_CLKS     = 32;

    // Capture FSM state encodings.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;

endpackage : pwm_capture_pkg
`default_nettype wire

// File: rtl/pwm_capture_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_edge
// Description : Two-flop synchronizer for one asynchronous gate pin, plus a
//               history flop for rise/fall detection.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               i_pin   - asynchronous pin input
//               o_level - synchronized pin level
//               o_rise  - one-cycle pulse on a synchronized rising edge
//               o_fall  - one-cycle pulse on a synchronized falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sync_edge
    import pwm_capture_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule : pwm_sync_edge
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Decodes a complementary PWM pair back into a duty word and a
//               rising-to-rising period, reports a stuck high-side leg,
//               a high-Z condition (both legs off) and a sticky
//               shoot-through fault (both legs on).
// Ports       : clock       - system clock
//               reset       - asynchronous active-high reset
//               pwm_h       - high-side gate pin (asynchronous)
//               pwm_l       - low-side gate pin (asynchronous)
//               duty_cycle  - last decoded high time, saturated
//               period      - last rising-to-rising period, saturated
//               valid       - one-cycle strobe on duty_cycle/period update
//               stuck       - no pwm_h edge for TIMEOUT_CLKS clocks
//               hiz         - both legs low for at least HIZ_CLKS clocks
//               shoot_fault - sticky: both legs were high together
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int DUTY_CYCLE_WIDTH = c_DEF_DUTY_CYCLE_WIDTH,
    parameter int CNT_WIDTH        = c_DEF_CNT_WIDTH,
    parameter int TIMEOUT_CLKS     = c_DEF_TIMEOUT_CLKS,
    parameter int HIZ_CLKS         = c_DEF_HIZ_CLKS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pwm_h,
    input  logic                        pwm_l,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic [CNT_WIDTH-1:0]        period,
    output logic                        valid,
    output logic                        stuck,
    output logic                        hiz,
    output logic                        shoot_fault
);

    localparam int c_IDLE_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int c_HIZ_W  = $clog2(HIZ_CLKS + 1);

    localparam logic [c_IDLE_W-1:0]  c_TIMEOUT    = c_IDLE_W'(TIMEOUT_CLKS);
    localparam logic [c_IDLE_W-1:0]  c_TIMEOUT_M1 = c_IDLE_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_HIZ_W-1:0]   c_HIZ        = c_HIZ_W'(HIZ_CLKS);
    localparam logic [CNT_WIDTH-1:0] c_DUTY_MAX   = CNT_WIDTH'((2 ** DUTY_CYCLE_WIDTH) - 1);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_h_level;
    logic w_h_rise;
    logic w_h_fall;
    logic w_l_level;
    logic w_l_rise;
    logic w_l_fall;

    pwm_sync_edge u_sync_h (
        .clk     (clock),
        .rst     (reset),
        .i_pin   (pwm_h),
        .o_level (w_h_level),
        .o_rise  (w_h_rise),
        .o_fall  (w_h_fall)
    );

    pwm_sync_edge u_sync_l (
        .clk     (clock),
        .rst     (reset),
        .i_pin   (pwm_l),
        .o_level (w_l_level),
        .o_rise  (w_l_rise),
        .o_fall  (w_l_fall)
    );

    // Only the low-leg level matters; its edge pulses are not needed.
    logic w_unused_l_edges;
    assign w_unused_l_edges = w_l_rise | w_l_fall;

    // ------------------------------------------------------------------
    // Saturating increments and duty clamp
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]        r_hi_cnt;
    logic [CNT_WIDTH-1:0]        r_per_cnt;
    logic [CNT_WIDTH-1:0]        w_hi_inc;
    logic [CNT_WIDTH-1:0]        w_per_inc;
    logic [DUTY_CYCLE_WIDTH-1:0] w_duty_sat;

    assign w_hi_inc   = (r_hi_cnt  == '1) ? r_hi_cnt  : r_hi_cnt  + CNT_WIDTH'(1);
    assign w_per_inc  = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + CNT_WIDTH'(1);
    assign w_duty_sat = (r_hi_cnt > c_DUTY_MAX) ? '1 : r_hi_cnt[DUTY_CYCLE_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Edge timeout: counter parks at the threshold so the timeout strobe
    // fires only once per stuck episode. An edge in the same cycle clears
    // the counter and suppresses the timeout.
    // ------------------------------------------------------------------
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_h_edge;
    logic                w_timeout;

    assign w_h_edge  = w_h_rise | w_h_fall;
    assign w_timeout = !w_h_edge && (r_idle_cnt == c_TIMEOUT_M1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_h_edge) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_TIMEOUT) begin
            r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM and published outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_hi_cnt   <= '0;
            r_per_cnt  <= '0;
            duty_cycle <= '0;
            period     <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_timeout) begin
                // Report the held level as 0% or 100% and drop the partial
                // measurement; a full period is needed before the next strobe.
                r_state    <= c_ST_IDLE;
                duty_cycle <= w_h_level ? '1 : '0;
                period     <= '0;
                valid      <= 1'b1;
                stuck      <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_h_rise) begin
                            r_state   <= c_ST_HIGH;
                            r_hi_cnt  <= CNT_WIDTH'(1);
                            r_per_cnt <= CNT_WIDTH'(1);
                        end
                    end
                    c_ST_HIGH: begin
                        r_per_cnt <= w_per_inc;
                        if (w_h_fall) begin
                            r_state <= c_ST_LOW;
                        end else begin
                            r_hi_cnt <= w_hi_inc;
                        end
                    end
                    c_ST_LOW: begin
                        if (w_h_rise) begin
                            duty_cycle <= w_duty_sat;
                            period     <= r_per_cnt;
                            valid      <= 1'b1;
                            stuck      <= 1'b0;
                            r_state    <= c_ST_HIGH;
                            r_hi_cnt   <= CNT_WIDTH'(1);
                            r_per_cnt  <= CNT_WIDTH'(1);
                        end else begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // High-Z detect and sticky shoot-through flag
    // ------------------------------------------------------------------
    logic [c_HIZ_W-1:0] r_hiz_cnt;
    logic [c_HIZ_W-1:0] w_hiz_next;
    logic               w_both_low;

    assign w_both_low = !w_h_level && !w_l_level;
    assign w_hiz_next = (r_hiz_cnt == c_HIZ) ? r_hiz_cnt : r_hiz_cnt + c_HIZ_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hiz_cnt   <= '0;
            hiz         <= 1'b0;
            shoot_fault <= 1'b0;
        end else begin
            if (w_both_low) begin
                r_hiz_cnt <= w_hiz_next;
                hiz       <= (w_hiz_next == c_HIZ);
            end else begin
                r_hiz_cnt <= '0;
                hiz       <= 1'b0;
            end
            if (w_h_level && w_l_level) begin
                shoot_fault <= 1'b1;
            end
        end
    end

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Scoreboard bench for pwm_capture. Stimulus tasks push the
//               expected publish for each completed period; a monitor pops
//               and compares whenever valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pwm_h = 1'b0;
    logic        pwm_l = 1'b1;
    logic [7:0]  duty_cycle;
    logic [15:0] period;
    logic        valid;
    logic        stuck;
    logic        hiz;
    logic        shoot_fault;

    pwm_capture #(
        .DUTY_CYCLE_WIDTH (8),
        .CNT_WIDTH        (16),
        .TIMEOUT_CLKS     (1024),
        .HIZ_CLKS         (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .duty_cycle  (duty_cycle),
        .period      (period),
        .valid       (valid),
        .stuck       (stuck),
        .hiz         (hiz),
        .shoot_fault (shoot_fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  duty;
        logic [15:0] per;
        logic        stk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   have_prev = 1'b0;
    int   prev_hi   = 0;
    int   prev_per  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected publish.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: actual duty=%0h period=%0d stuck=%0b required none",
                         duty_cycle, period, stuck);
            end else begin
                e = exp_q.pop_front();
                if (duty_cycle !== e.duty || period !== e.per || stuck !== e.stk) begin
                    failures++;
                    $display("FAIL publish: actual duty=%0h period=%0d stuck=%0b required duty=%0h period=%0d stuck=%0b",
                             duty_cycle, period, stuck, e.duty, e.per, e.stk);
                end
            end
        end
    end

    task automatic drive(input logic h, input logic l, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pwm_h = h;
            pwm_l = l;
        end
    endtask

    // The rise that starts a period publishes the previous complete period.
    task automatic push_prev();
        exp_t e;
        if (have_prev) begin
            e.duty = (prev_hi > 255) ? 8'hFF : 8'(prev_hi);
            e.per  = 16'(prev_per);
            e.stk  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_prev(input int hi, input int per);
        prev_hi   = hi;
        prev_per  = per;
        have_prev = 1'b1;
    endtask

    task automatic pwm_period(input int hi, input int per);
        push_prev();
        drive(1'b1, 1'b0, hi);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, per - hi - 4);
        drive(1'b0, 1'b0, 2);
        set_prev(hi, per);
    endtask

    // 16/256 period whose first dead band is stretched to 40 clocks.
    task automatic hiz_period();
        push_prev();
        drive(1'b1, 1'b0, 16);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 31) check("hiz_before_threshold", 32'(hiz), 32'd0);
            if (i == 36) check("hiz_asserted", 32'(hiz), 32'd1);
            pwm_h = 1'b0;
            pwm_l = 1'b0;
        end
        for (int j = 0; j < 198; j++) begin
            @(negedge clock);
            if (j == 1) check("hiz_held_until_sync", 32'(hiz), 32'd1);
            if (j == 5) check("hiz_cleared", 32'(hiz), 32'd0);
            pwm_h = 1'b0;
            pwm_l = 1'b1;
        end
        drive(1'b0, 1'b0, 2);
        set_prev(16, 256);
    endtask

    // 16/256 period with a single both-high clock inside the high phase,
    // so no extra pwm_h edge is created.
    task automatic shoot_period();
        push_prev();
        drive(1'b1, 1'b0, 8);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 7);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 236);
        drive(1'b0, 1'b0, 2);
        set_prev(16, 256);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"},  32'(duty_cycle),  32'd0);
        check({tag, "_period"}, 32'(period),     32'd0);
        check({tag, "_valid"}, 32'(valid),       32'd0);
        check({tag, "_stuck"}, 32'(stuck),       32'd0);
        check({tag, "_hiz"},   32'(hiz),         32'd0);
        check({tag, "_shoot"}, 32'(shoot_fault), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        exp_t e;
        #1 reset = 1'b1;
        drive(1'b0, 1'b1, 4);
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b1, 10);

        // Nominal 16/256 PWM.
        for (int k = 0; k < 4; k++) pwm_period(16, 256);
        check("nominal_stuck", 32'(stuck), 32'd0);
        check("nominal_hiz", 32'(hiz), 32'd0);
        check("nominal_shoot", 32'(shoot_fault), 32'd0);

        // Long high time saturates the duty word.
        pwm_period(300, 1000);
        pwm_period(300, 1000);
        pwm_period(16, 256);

        // Hold pwm_h high: the rise publishes the last period, then timeout.
        push_prev();
        have_prev = 1'b0;
        e.duty = 8'hFF;
        e.per  = 16'd0;
        e.stk  = 1'b1;
        exp_q.push_back(e);
        drive(1'b1, 1'b0, 1100);
        check("stuck_level", 32'(stuck), 32'd1);
        check("stuck_duty", 32'(duty_cycle), 32'hFF);
        check("stuck_period", 32'(period), 32'd0);

        // Resume; first rise only restarts measurement.
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 50);
        pwm_period(16, 256);
        pwm_period(16, 256);
        hiz_period();
        check("resume_stuck_cleared", 32'(stuck), 32'd0);
        check("resume_duty", 32'(duty_cycle), 32'h10);
        pwm_period(16, 256);

        // Shoot-through is sticky through normal PWM.
        shoot_period();
        check("shoot_set", 32'(shoot_fault), 32'd1);
        pwm_period(16, 256);
        pwm_period(16, 256);
        check("shoot_held", 32'(shoot_fault), 32'd1);
        check("shoot_hiz_clear", 32'(hiz), 32'd0);

        // Reset 100 clocks into a period.
        push_prev();
        drive(1'b1, 1'b0, 16);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 82);
        check("pre_reset_period", 32'(period), 32'd256);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        drive(1'b0, 1'b1, 5);
        @(negedge clock);
        reset = 1'b0;
        have_prev = 1'b0;
        drive(1'b0, 1'b1, 148);
        drive(1'b0, 1'b0, 2);
        pwm_period(16, 256);
        pwm_period(16, 256);
        push_prev();
        drive(1'b1, 1'b0, 10);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("post_reset_shoot", 32'(shoot_fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_capture
`default_nettype wire
